// File: rtl/mem_pkg.sv
// ============================================================================
// Module  : mem_pkg
// Purpose : Shared encodings and lane helpers for the data-memory access unit.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [7:0] TIMEOUT_CYCLES = 8'd255;

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      SZ_BYTE: is_aligned = 1'b1;
      SZ_HALF: is_aligned = ~addr[0];
      default: is_aligned = (addr == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      SZ_BYTE: byte_enable = 4'b0001 << addr;
      SZ_HALF: byte_enable = addr[1] ? 4'b1100 : 4'b0011;
      default: byte_enable = 4'b1111;
    endcase
  endfunction

  // Replicate the right-aligned store data into every lane so the byte
  // enables alone pick the target bytes.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: store_lanes = {4{data[7:0]}};
      SZ_HALF: store_lanes = {2{data[15:0]}};
      default: store_lanes = data;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_formatter.sv
// ============================================================================
// Module  : load_formatter
// Purpose : Selects the addressed lane of a read word and sign/zero-extends it.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module load_formatter
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    data   = rdata;
    case (addr)
      2'b00:   w_byte = rdata[7:0];
      2'b01:   w_byte = rdata[15:8];
      2'b10:   w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    w_half = addr[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: data = {{24{w_byte[7] & ~is_unsigned}}, w_byte};
      SZ_HALF: data = {{16{w_half[15] & ~is_unsigned}}, w_half};
      default: data = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module  : mem_access_unit
// Purpose : MEM-stage load/store sequencer with ack handshake and timeout.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_access_unit
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_memread,
  input  logic        MEM_memwrite,
  input  logic [1:0]  MEM_size,
  input  logic        MEM_unsigned,
  input  logic [31:0] MEM_aluresult,
  input  logic [31:0] MEM_writedata,
  output logic [31:0] MEM_memreaddata,
  output logic        stall,
  output logic        misalign,
  output logic        bus_error,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [7:0]  r_count;
  logic [7:0]  w_count_inc;
  logic [31:0] r_addr;
  logic [1:0]  r_lane;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_readdata;
  logic [31:0] w_fmt;
  logic        w_access;
  logic        w_aligned;
  logic        w_start;
  logic        w_timeout;

  assign w_access    = MEM_memread | MEM_memwrite;
  assign w_aligned   = is_aligned(MEM_size, MEM_aluresult[1:0]);
  assign w_start     = (r_state == ST_IDLE) & w_access & w_aligned;
  assign w_count_inc = r_count + 8'd1;
  // Timeout fires in the WAIT cycle whose missing ack would bring the count to the limit.
  assign w_timeout   = (r_state == ST_WAIT) & ~dmem_ack & (w_count_inc == TIMEOUT_CYCLES);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_next = ST_WAIT;
      ST_WAIT: if (dmem_ack || w_timeout) w_state_next = ST_DONE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    stall     = w_start | (r_state == ST_WAIT);
    dmem_req  = (r_state == ST_WAIT);
    dmem_we   = r_we & (r_state == ST_WAIT);
    misalign  = ~rst & (r_state == ST_IDLE) & w_access & ~w_aligned;
    bus_error = ~rst & w_timeout;
  end

  load_formatter u_load_formatter (
    .rdata       (dmem_rdata),
    .addr        (r_lane),
    .size        (r_size),
    .is_unsigned (r_unsigned),
    .data        (w_fmt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= 8'd0;
      r_addr     <= 32'd0;
      r_lane     <= 2'b00;
      r_we       <= 1'b0;
      r_be       <= 4'b0000;
      r_wdata    <= 32'd0;
      r_size     <= SZ_BYTE;
      r_unsigned <= 1'b0;
      r_readdata <= 32'd0;
    end else begin
      if (w_start) begin
        r_count    <= 8'd0;
        r_addr     <= {MEM_aluresult[31:2], 2'b00};
        r_lane     <= MEM_aluresult[1:0];
        r_we       <= ~MEM_memread;
        r_be       <= byte_enable(MEM_size, MEM_aluresult[1:0]);
        r_wdata    <= store_lanes(MEM_size, MEM_writedata);
        r_size     <= MEM_size;
        r_unsigned <= MEM_unsigned;
      end
      if ((r_state == ST_WAIT) && !dmem_ack) r_count <= w_count_inc;
      if ((r_state == ST_WAIT) && !r_we) begin
        if (dmem_ack)       r_readdata <= w_fmt;
        else if (w_timeout) r_readdata <= 32'd0;
      end
    end
  end

  assign dmem_addr       = r_addr;
  assign dmem_wdata      = r_wdata;
  assign dmem_be         = r_be;
  assign MEM_memreaddata = r_readdata;

endmodule

`default_nettype wire
